// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared definitions for the fetch front end. Holds the RISC-V
//                opcodes used by static prediction, the fetch FSM state type
//                and the J/B immediate extraction helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // REQ  : may present a group request to the I-cache
    // WAIT : one request outstanding, response expected
    // DROP : request outstanding but made stale by a redirect
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    // J-type immediate, sign-extended, bit 0 always zero
    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // B-type immediate, sign-extended, bit 0 always zero
    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_predecode.sv
`default_nettype none
// ============================================================================
//  Module      : inst_predecode
//  Description : Combinational static predictor for one fetch slot.
//                JAL is always taken; a conditional branch is taken when its
//                offset is negative (backward). Everything else, including
//                JALR, is predicted not taken.
//  Ports       : inst_i   - 32-bit instruction word
//                pc_i     - address of that instruction
//                taken_o  - 1 when the slot is predicted taken
//                target_o - predicted target (meaningful only when taken_o)
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_predecode
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [31:0]           inst_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    output logic                  taken_o,
    output logic [ADDR_WIDTH-1:0] target_o
);

    logic [6:0]         opcode;
    logic               is_jal;
    logic               is_bwd_br;
    logic signed [31:0] imm;

    always_comb begin
        opcode    = inst_i[6:0];
        is_jal    = (opcode == OPC_JAL);
        // inst[31] is the B-immediate sign bit, so it alone marks a backward branch
        is_bwd_br = (opcode == OPC_BRANCH) && inst_i[31];
        imm       = is_jal ? imm_j(inst_i) : imm_b(inst_i);
        taken_o   = is_jal | is_bwd_br;
        // signed cast sign-extends the offset to the PC width; sum wraps
        target_o  = pc_i + ADDR_WIDTH'(imm);
    end

endmodule
`default_nettype wire

// File: rtl/fetch_group_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_group_gen
//  Description : Fetch stage feeding the instruction buffer. Holds the fetch
//                PC, issues one aligned group request at a time to the
//                I-cache, predecodes the returned group, packs the valid
//                slots down to index 0 and writes them into the buffer.
//                Backend redirects replace the PC and discard any response
//                belonging to the old path.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                redirect_i/_pc_i    - backend flush and new fetch PC
//                inst_count_i        - instruction buffer occupancy
//                req_valid_o/ready_i - I-cache request handshake
//                req_addr_o          - group-aligned request address
//                resp_valid_i/data_i - I-cache group response (1-cycle pulse)
//                inst_o, pc_o        - packed instructions and their PCs
//                pred_res_o          - predicted-taken flag per packed slot
//                inst_wen_o          - buffer write mask, contiguous from bit 0
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_group_gen
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    Fetch_NUM  = 4,
    parameter int                    Depth      = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            redirect_i,
    input  logic [ADDR_WIDTH-1:0]           redirect_pc_i,
    input  logic [$clog2(Depth)-1:0]        inst_count_i,
    output logic                            req_valid_o,
    input  logic                            req_ready_i,
    output logic [ADDR_WIDTH-1:0]           req_addr_o,
    input  logic                            resp_valid_i,
    input  logic [Fetch_NUM*DATA_WIDTH-1:0] resp_data_i,
    output logic [DATA_WIDTH-1:0]           inst_o [Fetch_NUM],
    output logic [ADDR_WIDTH-1:0]           pc_o   [Fetch_NUM],
    output logic [Fetch_NUM-1:0]            pred_res_o,
    output logic [Fetch_NUM-1:0]            inst_wen_o
);

    localparam int SLOT_W    = $clog2(Fetch_NUM);
    localparam int GRP_BYTES = Fetch_NUM * 4;
    localparam int OFS       = $clog2(GRP_BYTES);
    localparam int CNT_W     = $clog2(Depth) + 1;

    // ------------------------------------------------------------------------
    // State. The PC is kept word-aligned: bits [1:0] are never stored.
    // ------------------------------------------------------------------------
    fetch_state_e                state_q,  state_d;
    logic [ADDR_WIDTH-1:2]       pc_q,     pc_d;
    logic [DATA_WIDTH-1:0]       inst_q    [Fetch_NUM];
    logic [DATA_WIDTH-1:0]       inst_d    [Fetch_NUM];
    logic [ADDR_WIDTH-1:0]       out_pc_q  [Fetch_NUM];
    logic [ADDR_WIDTH-1:0]       out_pc_d  [Fetch_NUM];
    logic [Fetch_NUM-1:0]        pred_q,   pred_d;
    logic [Fetch_NUM-1:0]        wen_q,    wen_d;

    // ------------------------------------------------------------------------
    // Group geometry and per-slot predecode
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]       aligned;
    logic [SLOT_W-1:0]           start;
    logic [DATA_WIDTH-1:0]       slot_inst   [Fetch_NUM];
    logic [ADDR_WIDTH-1:0]       slot_pc     [Fetch_NUM];
    logic [ADDR_WIDTH-1:0]       slot_target [Fetch_NUM];
    logic [Fetch_NUM-1:0]        slot_taken;

    assign aligned = {pc_q[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
    assign start   = pc_q[OFS-1:2];

    for (genvar j = 0; j < Fetch_NUM; j++) begin : g_slot
        assign slot_inst[j] = resp_data_i[j*DATA_WIDTH +: DATA_WIDTH];
        assign slot_pc[j]   = aligned + ADDR_WIDTH'(4 * j);

        inst_predecode #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_predecode (
            .inst_i   (slot_inst[j][31:0]),
            .pc_i     (slot_pc[j]),
            .taken_o  (slot_taken[j]),
            .target_o (slot_target[j])
        );
    end

    // ------------------------------------------------------------------------
    // Group formation: the run of slots from start up to the first predicted-
    // taken slot (or the last slot), shifted down so start lands in index 0.
    // ------------------------------------------------------------------------
    logic [SLOT_W-1:0]           end_idx;
    logic [SLOT_W-1:0]           last_idx;
    logic                        grp_taken;
    logic [DATA_WIDTH-1:0]       grp_inst [Fetch_NUM];
    logic [ADDR_WIDTH-1:0]       grp_pc   [Fetch_NUM];
    logic [Fetch_NUM-1:0]        grp_wen;
    logic [Fetch_NUM-1:0]        grp_pred;
    logic [ADDR_WIDTH-1:0]       next_pc;

    always_comb begin
        end_idx   = SLOT_W'(Fetch_NUM - 1);
        grp_taken = 1'b0;
        for (int j = 0; j < Fetch_NUM; j++) begin
            if (!grp_taken && (j >= int'(start)) && slot_taken[j]) begin
                end_idx   = SLOT_W'(j);
                grp_taken = 1'b1;
            end
        end

        // end_idx >= start always, so this never wraps
        last_idx = end_idx - start;

        for (int i = 0; i < Fetch_NUM; i++) begin
            grp_inst[i] = '0;
            grp_pc[i]   = '0;
            grp_wen[i]  = 1'b0;
            grp_pred[i] = 1'b0;
            if (SLOT_W'(i) <= last_idx) begin
                grp_inst[i] = slot_inst[start + SLOT_W'(i)];
                grp_pc[i]   = slot_pc[start + SLOT_W'(i)];
                grp_wen[i]  = 1'b1;
                grp_pred[i] = grp_taken && (SLOT_W'(i) == last_idx);
            end
        end

        next_pc = grp_taken ? slot_target[end_idx]
                            : aligned + ADDR_WIDTH'(GRP_BYTES);
    end

    // ------------------------------------------------------------------------
    // Request side. Throttle leaves room for the group sitting in the output
    // register plus the one about to be requested.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]            occ_ext;
    logic                        space_ok;

    assign occ_ext     = {1'b0, inst_count_i};
    assign space_ok    = (occ_ext + CNT_W'(2 * Fetch_NUM)) <= CNT_W'(Depth - 1);
    assign req_valid_o = ~rst & (state_q == REQ) & space_ok & ~redirect_i;
    // pc_q only moves on capture or redirect, neither of which can happen
    // while a request is held waiting for ready, so the address stays stable.
    assign req_addr_o  = aligned;

    // ------------------------------------------------------------------------
    // FSM and PC update
    // ------------------------------------------------------------------------
    logic                        capture;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;

        case (state_q)
            REQ: begin
                if (req_valid_o && req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (resp_valid_i) begin
                    // a redirect in the same cycle turns the response stale
                    capture = ~redirect_i;
                    state_d = REQ;
                end else if (redirect_i) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (resp_valid_i) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        if (capture) begin
            pc_d = next_pc[ADDR_WIDTH-1:2];
        end
        // redirect overrides the predicted next PC
        if (redirect_i) begin
            pc_d = redirect_pc_i[ADDR_WIDTH-1:2];
        end
    end

    always_comb begin
        for (int i = 0; i < Fetch_NUM; i++) begin
            inst_d[i]   = capture ? grp_inst[i] : inst_q[i];
            out_pc_d[i] = capture ? grp_pc[i]   : out_pc_q[i];
        end
        pred_d = capture ? grp_pred : pred_q;
        wen_d  = capture ? grp_wen  : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC[ADDR_WIDTH-1:2];
            pred_q  <= '0;
            wen_q   <= '0;
            for (int i = 0; i < Fetch_NUM; i++) begin
                inst_q[i]   <= '0;
                out_pc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pred_q  <= pred_d;
            wen_q   <= wen_d;
            for (int i = 0; i < Fetch_NUM; i++) begin
                inst_q[i]   <= inst_d[i];
                out_pc_q[i] <= out_pc_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The write strobe is masked by redirect so a buffer clear never
    // coincides with a write of wrong-path instructions.
    // ------------------------------------------------------------------------
    assign inst_o     = inst_q;
    assign pc_o       = out_pc_q;
    assign pred_res_o = pred_q;
    assign inst_wen_o = wen_q & {Fetch_NUM{~redirect_i}};

    // word-offset bits are deliberately dropped from the PC
    logic unused_pc_bits;
    assign unused_pc_bits = ^{redirect_pc_i[1:0], next_pc[1:0]};

endmodule
`default_nettype wire
